// File: rtl/host_cmd_master.sv
// host_cmd_master: frames host commands onto a UART byte link and collects replies.
// Optional response timeout enabled by defining HOST_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module host_cmd_master #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VLD,
  input  logic [1:0]  CMD_TYPE,
  input  logic [3:0]  CMD_ADDR,
  input  logic [7:0]  CMD_DATA,
  input  logic [7:0]  CMD_OPB,
  input  logic [3:0]  CMD_FUN,
  output logic        CMD_RDY,
  output logic [7:0]  TX_P_Data,
  output logic        TX_D_VLD,
  input  logic        Busy,
  input  logic [7:0]  RX_P_Data,
  input  logic        RX_D_VLD,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VLD,
  output logic        RSP_TIMEOUT
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_BH, WAIT_BL, RSP_WAIT
  } state_t;

  typedef struct packed {
    logic [1:0] typ;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] opb;
    logic [3:0] fun;
  } cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q;
  logic [2:0]  idx_q, idx_d;
  logic        rcnt_q, rcnt_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] rsp_q, rsp_d;
  logic        load;
  logic        tx_vld;
  logic        rsp_vld;
  logic [7:0]  tx_byte;
  logic [7:0]  frame_byte;
  logic [2:0]  last_idx;

`ifdef HOST_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        rsp_tmo;
`endif

  // frame byte at the current index and index of the final byte
  always_comb begin
    frame_byte = 8'h00;
    last_idx   = 3'd1;
    unique case (cmd_q.typ)
      2'b00: begin
        last_idx = 3'd2;
        case (idx_q)
          3'd0:    frame_byte = 8'hAA;
          3'd1:    frame_byte = {4'h0, cmd_q.addr};
          default: frame_byte = cmd_q.data;
        endcase
      end
      2'b01: begin
        case (idx_q)
          3'd0:    frame_byte = 8'hBB;
          default: frame_byte = {4'h0, cmd_q.addr};
        endcase
      end
      2'b10: begin
        last_idx = 3'd3;
        case (idx_q)
          3'd0:    frame_byte = 8'hCC;
          3'd1:    frame_byte = cmd_q.data;
          3'd2:    frame_byte = cmd_q.opb;
          default: frame_byte = {4'h0, cmd_q.fun};
        endcase
      end
      default: begin
        case (idx_q)
          3'd0:    frame_byte = 8'hDD;
          default: frame_byte = {4'h0, cmd_q.fun};
        endcase
      end
    endcase
  end

  // next-state, strobes and response assembly
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    lo_d    = lo_q;
    rsp_d   = rsp_q;
    load    = 1'b0;
    tx_vld  = 1'b0;
    tx_byte = 8'h00;
    rsp_vld = 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
    rsp_tmo = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (CMD_VLD) begin
          load    = 1'b1;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_byte = frame_byte;
        if (!Busy) begin
          tx_vld  = 1'b1;
          state_d = WAIT_BH;
        end
      end
      WAIT_BH: begin
        if (Busy) state_d = WAIT_BL;
      end
      WAIT_BL: begin
        if (!Busy) begin
          if (idx_q != last_idx) begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end else if (cmd_q.typ == 2'b00) begin
            rsp_vld = 1'b1;
            rsp_d   = 16'h0000;
            state_d = IDLE;
          end else begin
            rcnt_d  = 1'b0;
            state_d = RSP_WAIT;
          end
        end
      end
      RSP_WAIT: begin
        if (RX_D_VLD) begin
          if (cmd_q.typ == 2'b01) begin
            rsp_vld = 1'b1;
            rsp_d   = {8'h00, RX_P_Data};
            state_d = IDLE;
          end else if (!rcnt_q) begin
            lo_d   = RX_P_Data;
            rcnt_d = 1'b1;
          end else begin
            rsp_vld = 1'b1;
            rsp_d   = {RX_P_Data, lo_q};
            state_d = IDLE;
          end
        end
`ifdef HOST_CMD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rsp_tmo = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // state, latched command and response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      idx_q   <= 3'd0;
      rcnt_q  <= 1'b0;
      lo_q    <= 8'h00;
      rsp_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load) begin
        cmd_q <= {CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN};
      end
      idx_q  <= idx_d;
      rcnt_q <= rcnt_d;
      lo_q   <= lo_d;
      rsp_q  <= rsp_d;
    end
  end

`ifdef HOST_CMD_TIMEOUT_EN
  // idle-cycle counter, restarted on entry and on every reply byte
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != RSP_WAIT) tmo_d = 16'h0000;
    else if (RX_D_VLD)       tmo_d = 16'h0000;
    else                     tmo_d = tmo_q + 16'h0001;
  end

  // timeout counter register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tmo_q <= 16'h0000;
    else      tmo_q <= tmo_d;
  end

  assign RSP_TIMEOUT = rsp_tmo;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

  assign CMD_RDY   = (state_q == IDLE);
  assign TX_D_VLD  = tx_vld;
  assign TX_P_Data = tx_byte;
  assign RSP_VLD   = rsp_vld;
  assign RSP_DATA  = rsp_vld ? rsp_d : rsp_q;

endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master: random + directed scoreboard bench for host_cmd_master.
// Timeout scenario runs when HOST_CMD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_host_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VLD;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR;
  logic [7:0]  CMD_DATA;
  logic [7:0]  CMD_OPB;
  logic [3:0]  CMD_FUN;
  logic        CMD_RDY;
  logic [7:0]  TX_P_Data;
  logic        TX_D_VLD;
  logic        Busy;
  logic [7:0]  RX_P_Data;
  logic        RX_D_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  host_cmd_master #(.TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VLD(CMD_VLD), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
    .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
    .CMD_RDY(CMD_RDY), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
    .Busy(Busy), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          tmo;
    logic [15:0] data;
  } rsp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          tx_seen = 0;
  int          tmo_cyc = 0;
  int          busy_len = 0;
  int          busy_cnt = 0;
  bit          pend = 0;
  bit          force_busy = 0;
  bit          rdy_chk = 0;
  logic [15:0] exp_hold = 16'h0000;
  logic [7:0]  txq[$];
  rsp_t        rspq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // UART transmitter model: busy for a while after each strobe
  initial forever begin
    @(negedge CLK);
    if (TX_D_VLD) pend = 1'b1;
  end

  initial begin
    Busy = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (pend) begin
        busy_cnt = (busy_len > 0) ? busy_len : int'($urandom_range(1, 10));
        pend = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      Busy = force_busy || (busy_cnt > 0);
    end
  end

  // monitor: compare every DUT output event against the scoreboard
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      if (rdy_chk) begin
        check("cmd_rdy_after_rsp", {31'd0, CMD_RDY}, 32'd1);
        rdy_chk = 1'b0;
      end
      if (TX_D_VLD) begin
        tx_seen++;
        if (txq.size() == 0) fail_now("tx_unexpected");
        else check("tx_byte", {24'd0, TX_P_Data}, {24'd0, txq.pop_front()});
      end
      if (RSP_VLD || RSP_TIMEOUT) begin
        rsp_t r;
        tmo_cyc = cyc;
        rdy_chk = 1'b1;
        check("rdy_low_on_rsp", {31'd0, CMD_RDY}, 32'd0);
        if (rspq.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          r = rspq.pop_front();
          check("rsp_timeout", {31'd0, RSP_TIMEOUT}, {31'd0, r.tmo});
          check("rsp_vld", {31'd0, RSP_VLD}, {31'd0, !r.tmo});
          if (!r.tmo) begin
            check("rsp_data", {16'd0, RSP_DATA}, {16'd0, r.data});
            exp_hold = r.data;
          end else begin
            check("rsp_data_kept", {16'd0, RSP_DATA}, {16'd0, exp_hold});
          end
        end
      end
    end
  end

  // reference model: frame bytes and reply from the command definition
  task automatic model(input logic [1:0] t, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] b,
                       input logic [3:0] f, input logic [7:0] r0,
                       input logic [7:0] r1, input bit tmo);
    rsp_t r;
    r.tmo = tmo;
    case (t)
      2'd0: begin
        txq.push_back(8'hAA); txq.push_back({4'h0, a}); txq.push_back(d);
        r.data = 16'h0000;
      end
      2'd1: begin
        txq.push_back(8'hBB); txq.push_back({4'h0, a});
        r.data = 16'h0000 + r0;
      end
      2'd2: begin
        txq.push_back(8'hCC); txq.push_back(d); txq.push_back(b);
        txq.push_back({4'h0, f});
        r.data = r1 * 256 + r0;
      end
      default: begin
        txq.push_back(8'hDD); txq.push_back({4'h0, f});
        r.data = r1 * 256 + r0;
      end
    endcase
    rspq.push_back(r);
  endtask

  task automatic rx_byte(input logic [7:0] v);
    RX_D_VLD = 1'b1;
    RX_P_Data = v;
    tick();
    RX_D_VLD = 1'b0;
    RX_P_Data = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] b,
                         input logic [3:0] f, input logic [7:0] r0,
                         input logic [7:0] r1, input bit stray,
                         input int hold, input bit tmo);
    int n;
    int base;
    int rx_cyc;
    n = 0;
    while (!CMD_RDY && n < 300) begin tick(); n++; end
    if (!CMD_RDY) fail_now("cmd_rdy_wait");
    model(t, a, d, b, f, r0, r1, tmo);
    base = tx_seen;
    CMD_VLD = 1'b1;
    CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d; CMD_OPB = b; CMD_FUN = f;
    tick();
    CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom);
    CMD_DATA = 8'($urandom); CMD_OPB = 8'($urandom);
    CMD_FUN = 4'($urandom);
    tick();
    CMD_VLD = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i == 3) rx_byte(8'($urandom));
        else tick();
      end
      check("no_tx_while_busy", tx_seen - base, 32'd0);
      force_busy = 1'b0;
    end
    n = 0;
    while (tx_seen == base && n < 100) begin tick(); n++; end
    if (stray) rx_byte(8'($urandom));
    n = 0;
    while (txq.size() > 0 && n < 400) begin tick(); n++; end
    if (txq.size() > 0) begin
      fail_now("tx_frame_wait");
      txq.delete();
    end
    repeat (2) tick();
    n = 0;
    while (Busy && n < 50) begin tick(); n++; end
    repeat (2) tick();
    rx_cyc = cyc;
    if (t != 2'd0) begin
      rx_cyc = cyc;
      rx_byte(r0);
      if (t[1] && !tmo) begin
        repeat ($urandom_range(0, 3)) tick();
        rx_byte(r1);
      end
    end
    n = 0;
    while (rspq.size() > 0 && n < 300) begin tick(); n++; end
    if (rspq.size() > 0) begin
      fail_now("rsp_wait");
      rspq.delete();
    end
    if (tmo) check("tmo_latency", tmo_cyc - rx_cyc, 32'd8);
    tick();
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_rdy"}, {31'd0, CMD_RDY}, 32'd1);
    check({tag, "_txv"}, {31'd0, TX_D_VLD}, 32'd0);
    check({tag, "_txd"}, {24'd0, TX_P_Data}, 32'd0);
    check({tag, "_rspd"}, {16'd0, RSP_DATA}, 32'd0);
    check({tag, "_rspv"}, {31'd0, RSP_VLD}, 32'd0);
    check({tag, "_tmo"}, {31'd0, RSP_TIMEOUT}, 32'd0);
  endtask

  initial begin
    int n;
    RST = 1'b0;
    CMD_VLD = 1'b0; CMD_TYPE = 2'd0; CMD_ADDR = 4'd0;
    CMD_DATA = 8'd0; CMD_OPB = 8'd0; CMD_FUN = 4'd0;
    RX_P_Data = 8'd0; RX_D_VLD = 1'b0;
    #3;
    chk_reset("por");
    repeat (3) tick();
    RST = 1'b1;
    tick();

    busy_len = 10;
    run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    busy_len = 0;
    run_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 8'h7E, 8'h00, 1'b0, 0, 1'b0);
    run_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 8'h46, 8'h00, 1'b0, 0, 1'b0);

    force_busy = 1'b1;
    Busy = 1'b1;
    run_cmd(2'd1, 4'h9, 8'h00, 8'h00, 4'h0, 8'hA5, 8'h00, 1'b1, 12, 1'b0);

`ifdef HOST_CMD_TIMEOUT_EN
    run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h6, 8'h5A, 8'h00, 1'b0, 0, 1'b1);
`endif

    run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 8'h11, 8'hE2, 1'b1, 0, 1'b0);

    busy_len = 10;
    model(2'd0, 4'h3, 8'h99, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    n = tx_seen;
    CMD_VLD = 1'b1; CMD_TYPE = 2'd0; CMD_ADDR = 4'h3; CMD_DATA = 8'h99;
    tick();
    CMD_VLD = 1'b0;
    while (tx_seen == n) tick();
    repeat (4) tick();
    RST = 1'b0;
    #1;
    chk_reset("midrst");
    txq.delete();
    rspq.delete();
    exp_hold = 16'h0000;
    rdy_chk = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    busy_len = 0;
    run_cmd(2'd2, 4'h0, 8'h21, 8'h43, 4'hB, 8'hC4, 8'h3D, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
              4'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 0, 1'b0);
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 Parameter: TIMEOUT_CYC, 4096, response-wait limit in CLK cycles; legal range 2..65535.
REQ-002 Port: CLK  in  1  system clock; all state changes on the rising edge.
REQ-003 Port: RST  in  1  asynchronous, active-low reset.
REQ-004 Port: CMD_VLD  in  1  command request; accepted only on a cycle with CMD_RDY=1.
REQ-005 Port: CMD_TYPE  in  2  command type: 00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-006 Port: CMD_ADDR  in  4  register address.
REQ-007 Port: CMD_DATA  in  8  write data, or operand A.
REQ-008 Port: CMD_OPB  in  8  operand B.
REQ-009 Port: CMD_FUN  in  4  ALU function code.
REQ-010 Port: CMD_RDY  out  1  high only in IDLE.
REQ-011 Port: TX_P_Data  out  8  byte to UART transmitter.
REQ-012 Port: TX_D_VLD  out  1  one-cycle byte strobe to UART transmitter.
REQ-013 Port: Busy  in  1  UART transmitter busy.
REQ-014 Port: RX_P_Data  in  8  byte from UART receiver.
REQ-015 Port: RX_D_VLD  in  1  one-cycle receive strobe.
REQ-016 Port: RSP_DATA  out  16  response value; held until the next RSP_VLD.
REQ-017 Port: RSP_VLD  out  1  one-cycle command-complete pulse.
REQ-018 Port: RSP_TIMEOUT  out  1  one-cycle response-timeout pulse.

Function
REQ-019 The block SHALL latch all CMD_* fields on acceptance; later input changes have no effect on the command in flight.
REQ-020 The block SHALL send these frames, left byte first: write = AA,{4'h0,ADDR},DATA; read = BB,{4'h0,ADDR}; ALU with operands = CC,DATA,OPB,{4'h0,FUN}; ALU without operands = DD,{4'h0,FUN}.
REQ-021 The FSM SHALL have the states IDLE, SEND, WAIT_BH, WAIT_BL and RSP_WAIT.
REQ-022 Transitions: IDLE->SEND on acceptance; SEND->WAIT_BH after a one-cycle TX_D_VLD with TX_P_Data valid in the same cycle.
REQ-023 Transitions (continued): WAIT_BH->WAIT_BL when Busy=1; WAIT_BL->SEND when Busy=0 and frame bytes remain.
REQ-024 The block SHALL issue TX_D_VLD in SEND only when Busy=0; otherwise it stays in SEND.
REQ-025 On the last byte's WAIT_BL exit (Busy=0), a write SHALL go to IDLE with RSP_VLD=1 and RSP_DATA=16'h0000; all other types go to RSP_WAIT.
REQ-026 In RSP_WAIT, read SHALL complete on the first RX byte: RSP_DATA={8'h00,byte}, RSP_VLD=1, next state IDLE.
REQ-027 In RSP_WAIT, ALU commands SHALL complete on the second RX byte: first byte = RSP_DATA[7:0], second = [15:8].
REQ-028 RX_D_VLD outside RSP_WAIT SHALL be discarded, and SHALL NOT alter RSP_DATA or the byte count.
REQ-029 CMD_VLD while CMD_RDY=0 SHALL be ignored, with no queuing.
REQ-030 CMD_RDY SHALL rise in the cycle after RSP_VLD or RSP_TIMEOUT; back-to-back commands are legal from that cycle.
REQ-031 A byte index counter (3 bits) SHALL clear on acceptance, and a response byte counter (1 bit) SHALL clear on RSP_WAIT entry.

Reset
REQ-032 RST low SHALL force, asynchronously and mid-operation included: state IDLE, CMD_RDY=1, TX_D_VLD=0, TX_P_Data=8'h00, RSP_DATA=16'h0000, RSP_VLD=0, RSP_TIMEOUT=0, and all counters 0.
REQ-033 Any in-flight command SHALL be abandoned without a response pulse.

Configuration
REQ-034 With HOST_CMD_TIMEOUT_EN defined, a 16-bit counter SHALL clear on RSP_WAIT entry and on each RX_D_VLD in RSP_WAIT, and increment otherwise.
REQ-035 With HOST_CMD_TIMEOUT_EN defined, reaching TIMEOUT_CYC-1 SHALL pulse RSP_TIMEOUT, return to IDLE and leave RSP_DATA unchanged.
REQ-036 With HOST_CMD_TIMEOUT_EN defined, RX_D_VLD in the same cycle as expiry SHALL take priority, so the byte is taken and the counter cleared.
REQ-037 Without HOST_CMD_TIMEOUT_EN, RSP_WAIT SHALL wait indefinitely, RSP_TIMEOUT SHALL be tied 0, and no counter is synthesised.

Verification
REQ-038 Write: TYPE=00, ADDR=5, DATA=3C; Busy model high 10 cycles per byte -> TX bytes AA,05,3C, then RSP_VLD with RSP_DATA=0000.
REQ-039 Read: TYPE=01, ADDR=2; RX 7E -> TX BB,02, then RSP_VLD with RSP_DATA=007E.
REQ-040 ALU: TYPE=10, A=12, B=34, FUN=1; RX 46 then 00 -> TX CC,12,34,01, then RSP_DATA=0046.
REQ-041 Busy held high before a byte -> no TX_D_VLD until Busy=0; a CMD_VLD during the frame is ignored; an RX byte arriving in SEND is dropped.
REQ-042 Timeout (macro on, TIMEOUT_CYC=8): TYPE=11, RX one byte then silence -> RSP_TIMEOUT 8 cycles after that byte, CMD_RDY=1 next cycle.
REQ-043 RST low during WAIT_BL -> all outputs reset immediately; a new command after reset completes normally.
